coin_panel_frontend: RTL and testbench

COIN_PANEL_FRONTEND -- requirements
Module: coin_panel_frontend

---
 rtl/coin_panel_frontend.sv | 158 +++++++++++++++
 tb/tb_coin_panel_frontend.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/coin_panel_frontend.sv
// Coin acceptor front end: accumulates credit, starts the wash controller, returns change/rejects.
// Optional idle auto-refund in COLLECT is enabled with `define CP_IDLE_TIMEOUT_EN.
module coin_panel_frontend #(
  parameter int CREDIT_WIDTH = 6,
  parameter int PRICE_SINGLE = 10,
  parameter int PRICE_DOUBLE = 15,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coin_strobe,
  input  logic [1:0]              coin_value,
  input  logic                    select_double,
  input  logic                    cancel,
  input  logic                    wash_done,
  output logic                    coin_in,
  output logic                    double_wash,
  output logic [CREDIT_WIDTH-1:0] credit,
  output logic                    refund_valid,
  output logic [CREDIT_WIDTH-1:0] refund_amount,
  output logic                    busy
);

  // Internal arithmetic is one bit wider than the larger of credit and coin width, so sums never wrap.
  localparam int SW = ((CREDIT_WIDTH > 4) ? CREDIT_WIDTH : 4) + 1;
  localparam logic [SW-1:0] CMAX     = {{(SW-CREDIT_WIDTH){1'b0}}, {CREDIT_WIDTH{1'b1}}};
  localparam logic [SW-1:0] P_SINGLE = SW'(PRICE_SINGLE);
  localparam logic [SW-1:0] P_DOUBLE = SW'(PRICE_DOUBLE);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_START, S_RUN} state_e;

  state_e                  state_q, state_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic [CREDIT_WIDTH-1:0] refund_amount_q, refund_amount_d;
  logic                    refund_valid_q, refund_valid_d;
  logic                    double_wash_q, double_wash_d;
  logic                    coin_in_q, coin_in_d;
  logic                    busy_q, busy_d;

  logic [SW-1:0] coin_amt, credit_ext, sum, price, credit_nx, refund_nx;
  logic          timeout;

`ifdef CP_IDLE_TIMEOUT_EN
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;

  assign timeout = (state_q == S_COLLECT) && !coin_strobe && (timer_q == TW'(IDLE_TIMEOUT - 1));

  always_comb begin
    timer_d = '0;
    if (state_q == S_COLLECT && !coin_strobe) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    coin_amt = '0;
    if (coin_strobe) begin
      case (coin_value)
        2'b00:   coin_amt = SW'(1);
        2'b01:   coin_amt = SW'(2);
        2'b10:   coin_amt = SW'(5);
        default: coin_amt = SW'(10);
      endcase
    end
    credit_ext = {{(SW-CREDIT_WIDTH){1'b0}}, credit_q};
    sum        = credit_ext + coin_amt;
    price      = select_double ? P_DOUBLE : P_SINGLE;

    state_d       = state_q;
    credit_nx     = credit_ext;
    refund_nx     = '0;
    double_wash_d = double_wash_q;

    case (state_q)
      S_IDLE: begin
        if (coin_strobe) begin
          state_d = S_COLLECT;
          if (sum > CMAX) begin credit_nx = CMAX; refund_nx = sum - CMAX; end
          else credit_nx = sum;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          refund_nx = sum;
          credit_nx = '0;
          state_d   = S_IDLE;
        end else if (credit_ext >= price) begin
          // a coin arriving on the start cycle is returned along with the change
          refund_nx     = credit_ext - price + coin_amt;
          credit_nx     = '0;
          double_wash_d = select_double;
          state_d       = S_START;
        end else if (timeout) begin
          refund_nx = credit_ext;
          credit_nx = '0;
          state_d   = S_IDLE;
        end else if (sum > CMAX) begin
          credit_nx = CMAX;
          refund_nx = sum - CMAX;
        end else begin
          credit_nx = sum;
        end
      end
      S_START: begin
        refund_nx = coin_amt;
        if (!wash_done) state_d = S_RUN;
      end
      default: begin
        refund_nx = coin_amt;
        if (wash_done) begin
          state_d       = S_IDLE;
          double_wash_d = 1'b0;
        end
      end
    endcase

    credit_d        = credit_nx[CREDIT_WIDTH-1:0];
    refund_valid_d  = (refund_nx != '0);
    refund_amount_d = (refund_nx > CMAX) ? {CREDIT_WIDTH{1'b1}} : refund_nx[CREDIT_WIDTH-1:0];
    coin_in_d       = (state_d == S_START);
    busy_d          = (state_d == S_START) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      credit_q        <= '0;
      refund_amount_q <= '0;
      refund_valid_q  <= 1'b0;
      double_wash_q   <= 1'b0;
      coin_in_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      refund_amount_q <= refund_amount_d;
      refund_valid_q  <= refund_valid_d;
      double_wash_q   <= double_wash_d;
      coin_in_q       <= coin_in_d;
      busy_q          <= busy_d;
    end
  end

  assign credit        = credit_q;
  assign refund_amount = refund_amount_q;
  assign refund_valid  = refund_valid_q;
  assign double_wash   = double_wash_q;
  assign coin_in       = coin_in_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_coin_panel_frontend.sv
// Directed vector bench for coin_panel_frontend (default build, idle timeout disabled).
module tb_coin_panel_frontend;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_strobe, select_double, cancel, wash_done;
  logic [1:0] coin_value;
  logic       coin_in, double_wash, refund_valid, busy;
  logic [5:0] credit, refund_amount;

  int checks = 0;
  int errors = 0;

  coin_panel_frontend dut (
    .clk(clk), .rst_n(rst_n), .coin_strobe(coin_strobe), .coin_value(coin_value),
    .select_double(select_double), .cancel(cancel), .wash_done(wash_done),
    .coin_in(coin_in), .double_wash(double_wash), .credit(credit),
    .refund_valid(refund_valid), .refund_amount(refund_amount), .busy(busy)
  );

  always #5 clk = ~clk;

  // cv: 0=1 unit, 1=2, 2=5, 3=10; expected outputs are those seen after the edge that samples the row
  typedef struct {
    bit       cs;
    bit [1:0] cv;
    bit       sel, cnl, wd;
    int       cr;
    bit       ci, dw, by, rv;
    int       ra;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit cs, input bit [1:0] cv, input bit sel, input bit cnl, input bit wd);
    coin_strobe = cs; coin_value = cv; select_double = sel; cancel = cnl; wash_done = wd;
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, " credit"},        int'(credit),        v.cr);
    chk({tag, " coin_in"},       int'(coin_in),       int'(v.ci));
    chk({tag, " double_wash"},   int'(double_wash),   int'(v.dw));
    chk({tag, " busy"},          int'(busy),          int'(v.by));
    chk({tag, " refund_valid"},  int'(refund_valid),  int'(v.rv));
    chk({tag, " refund_amount"}, int'(refund_amount), v.ra);
  endtask

  initial begin
    bit rv_seen;
    vec_t z;
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    z = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    chk_outs("reset", z);
    rst_n = 1'b1;

    //            cs cv sel cnl wd  cr ci dw by rv ra
    // coins 5,5 single -> start two cycles after second coin; coin rejected in RUN
    tbl.push_back('{1, 2, 0, 0, 1,  5, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 1, 10, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0,  0, 0, 0, 1, 1, 5});
    tbl.push_back('{0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0});
    // coins 10,10 single -> 10 change with the start
    tbl.push_back('{1, 3, 0, 0, 1, 10, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 3, 0, 0, 1,  0, 1, 0, 1, 1, 10});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0});
    // coins 10,5 double -> double_wash held through the cycle; coin rejected in START
    tbl.push_back('{1, 3, 1, 0, 1, 10, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 1, 0, 1, 15, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 1,  0, 1, 1, 1, 0, 0});
    tbl.push_back('{1, 1, 1, 0, 0,  0, 0, 1, 1, 1, 2});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0});
    // coin 2, then cancel with coin 1 -> refund 3; cancel in IDLE ignored
    tbl.push_back('{1, 1, 0, 0, 1,  2, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 1,  0, 0, 0, 0, 1, 3});
    tbl.push_back('{0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0});
    // credit 11: held below double price, starts single with 1 change once selection drops
    tbl.push_back('{1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 3, 0, 0, 1, 11, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 1, 11, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 1, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0});
    // cancel wins over a pending start
    tbl.push_back('{1, 3, 0, 0, 1, 10, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 10});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      drive(tbl[i].cs, tbl[i].cv, tbl[i].sel, tbl[i].cnl, tbl[i].wd);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), tbl[i]);
    end

    // no idle timeout in this build: credit 2 survives well past IDLE_TIMEOUT
    drive(1, 1, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    rv_seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (refund_valid) rv_seen = 1'b1;
    end
    chk("hold credit", int'(credit), 2);
    chk("hold no refund", int'(rv_seen), 0);
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("hold cancel refund", int'(refund_amount), 2);
    chk("hold cancel credit", int'(credit), 0);
    drive(0, 0, 0, 0, 1);

    // reset mid-COLLECT drops credit without a refund pulse
    drive(1, 2, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    chk("pre-reset credit", int'(credit), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset credit", int'(credit), 0);
    chk("async reset refund_valid", int'(refund_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (refund_valid) rv_seen = 1'b1;
    end
    chk("post-reset no refund", int'(rv_seen), 0);
    chk("post-reset credit", int'(credit), 0);
    chk("post-reset busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
